bus_fabric_rr: RTL and testbench

Parametrised shared-bus fabric for the SoC top level. It connects NUM_M bus masters (CPU IF/MEM stages, future DMA) to NUM_S memory-mapped slaves (ROM, SPM, timer, UART, GPIO, expansion).
- Fixed-priority arbitration is replaced by registered round-robin arbitration.
- Address decode is sized from NUM_S.
- An optional bus-timeout watchdog terminates accesses to absent or hung slaves with an error response.

---
 rtl/bus_fabric_rr.sv | 199 +++++++++++++++++++
 tb/tb_bus_fabric_rr.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fabric_rr.sv
// ---------------------------------------------------------------------------
// bus_fabric_rr
//
// Shared-bus fabric connecting NUM_M masters to NUM_S memory-mapped slaves.
// A registered round-robin arbiter picks one owner. The owner's address
// phase is muxed onto the shared slave bus. The top SEL_W address bits
// select one slave chip select, and that slave's read data and ready are
// returned to the masters.
//
// Optional feature, enabled by defining BUS_FABRIC_TIMEOUT_EN:
//   A bus-timeout watchdog. After TIMEOUT wait cycles it terminates the
//   stalled access with ERR_DATA and a one-cycle bus_err pulse, and it
//   records the address of that access in err_addr.
//   When the macro is undefined there is no watchdog: bus_err and err_addr
//   are tied to 0, and a slave that never answers stalls its owner.
//
// Ports:
//   clk, reset          system clock; asynchronous active-high reset
//   m_req_, m_as_       per-master request / address strobe (active low)
//   m_addr, m_rw        per-master word address / direction (1 = read)
//   m_wr_data           per-master write data
//   m_grnt_             per-master grant, active low, registered
//   m_rd_data, m_rdy_   shared read data / ready (active low) to masters
//   s_addr, s_as_       shared slave address / strobe (active low)
//   s_rw, s_wr_data     shared slave direction / write data
//   s_cs_               per-slave chip select, active low
//   s_rd_data, s_rdy_   per-slave read data / ready (active low)
//   bus_err, err_addr   timeout pulse / address of last timed-out access
// ---------------------------------------------------------------------------
module bus_fabric_rr #(
  parameter int               NUM_M    = 4,
  parameter int               NUM_S    = 8,
  parameter int               ADDR_W   = 30,
  parameter int               DATA_W   = 32,
  parameter int               TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_M-1:0]         m_req_,
  input  logic [NUM_M*ADDR_W-1:0]  m_addr,
  input  logic [NUM_M-1:0]         m_as_,
  input  logic [NUM_M-1:0]         m_rw,
  input  logic [NUM_M*DATA_W-1:0]  m_wr_data,
  output logic [NUM_M-1:0]         m_grnt_,
  output logic [DATA_W-1:0]        m_rd_data,
  output logic                     m_rdy_,
  output logic [ADDR_W-1:0]        s_addr,
  output logic                     s_as_,
  output logic                     s_rw,
  output logic [DATA_W-1:0]        s_wr_data,
  output logic [NUM_S-1:0]         s_cs_,
  input  logic [NUM_S*DATA_W-1:0]  s_rd_data,
  input  logic [NUM_S-1:0]         s_rdy_,
  output logic                     bus_err,
  output logic [ADDR_W-1:0]        err_addr
);

  localparam int SEL_W = $clog2(NUM_S);
  localparam int OWN_W = $clog2(NUM_M);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state, state_nxt;
  logic [OWN_W-1:0] owner, owner_nxt;
  logic [OWN_W-1:0] last_owner, last_owner_nxt;
  logic [OWN_W-1:0] base, cand, pick;
  logic             pick_vld;
  logic [NUM_M-1:0] grnt_nxt;
  logic [SEL_W-1:0] sel;
  logic             tmo;

  // ---------------- arbiter: next state ----------------
  // The search starts one past the current owner when the owner releases,
  // and one past the last owner when idle. In both cases the master that
  // released most recently is ranked last.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    base           = (state == OWNED) ? owner : last_owner;
    cand           = '0;
    pick           = '0;
    pick_vld       = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand = OWN_W'((int'(base) + k) % NUM_M);
      if (!pick_vld && !m_req_[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end

    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = OWNED;
          owner_nxt = pick;
        end
      end
      OWNED: begin
        // No preemption: the grant moves only when the owner lets go.
        if (m_req_[owner]) begin
          last_owner_nxt = owner;
          if (pick_vld) owner_nxt = pick;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    grnt_nxt = '1;
    if (state_nxt == OWNED) grnt_nxt[owner_nxt] = 1'b0;
  end

  // ---------------- arbiter: state register ----------------
  // The last owner resets to NUM_M-1, so master 0 wins the first arbitration.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OWN_W'(NUM_M - 1);
      m_grnt_    <= '1;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      m_grnt_    <= grnt_nxt;
    end
  end

  // ---------------- master mux ----------------
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (state == OWNED) begin
      s_addr    = m_addr[int'(owner)*ADDR_W +: ADDR_W];
      s_as_     = m_as_[owner];
      s_rw      = m_rw[owner];
      s_wr_data = m_wr_data[int'(owner)*DATA_W +: DATA_W];
    end
  end

  // ---------------- decoder ----------------
  assign sel = s_addr[ADDR_W-1 -: SEL_W];

  // The chip select follows ownership, not the strobe, so a slave sees its
  // select for the whole tenure of an owner addressing it.
  always_comb begin
    s_cs_ = '1;
    if (state == OWNED) s_cs_[sel] = 1'b0;
  end

  // ---------------- slave mux with timeout override ----------------
  always_comb begin
    m_rd_data = '0;
    m_rdy_    = 1'b1;
    if (tmo) begin
      m_rd_data = ERR_DATA;
      m_rdy_    = 1'b0;
    end else if (!s_as_) begin
      m_rd_data = s_rd_data[int'(sel)*DATA_W +: DATA_W];
      m_rdy_    = s_rdy_[sel];
    end
  end

`ifdef BUS_FABRIC_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        stall;

  // The counter value equals the number of cycles the current access has
  // waited so far, so the override fires on the TIMEOUT-th wait cycle.
  assign stall   = !s_as_ && s_rdy_[sel];
  assign tmo     = stall && (wait_cnt == 16'(TIMEOUT));
  assign bus_err = tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err_addr <= '0;
    end else begin
      if (!stall || tmo) wait_cnt <= '0;
      else               wait_cnt <= wait_cnt + 16'd1;
      if (tmo) err_addr <= s_addr;
    end
  end
`else
  logic unused_cfg;

  assign tmo        = 1'b0;
  assign bus_err    = 1'b0;
  assign err_addr   = '0;
  assign unused_cfg = ^{ERR_DATA, 32'(TIMEOUT)};
`endif

endmodule

// File: tb/tb_bus_fabric_rr.sv
// ---------------------------------------------------------------------------
// tb_bus_fabric_rr
//
// Self-checking bench for bus_fabric_rr (NUM_M=4, NUM_S=8, TIMEOUT=15).
// It covers the reset state, an asynchronous mid-transfer reset, grant
// latency and handover, and a round-robin grant order. The expected order
// is queued when the requests are driven and popped as grants appear. A
// decode/mux vector table is also applied. The last sequence is the
// watchdog scenario, checked against whichever build
// (BUS_FABRIC_TIMEOUT_EN) is compiled.
// ---------------------------------------------------------------------------
module tb_bus_fabric_rr;

  localparam int NUM_M  = 4;
  localparam int NUM_S  = 8;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

`ifdef BUS_FABRIC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_M-1:0]        m_req_, m_as_, m_rw, m_grnt_;
  logic [NUM_M*ADDR_W-1:0] m_addr;
  logic [NUM_M*DATA_W-1:0] m_wr_data;
  logic [DATA_W-1:0]       m_rd_data, s_wr_data;
  logic                    m_rdy_, s_as_, s_rw, bus_err;
  logic [ADDR_W-1:0]       s_addr, err_addr;
  logic [NUM_S-1:0]        s_cs_, s_rdy_;
  logic [NUM_S*DATA_W-1:0] s_rd_data;

  bus_fabric_rr #(
    .NUM_M(NUM_M), .NUM_S(NUM_S), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .TIMEOUT(15), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .m_req_(m_req_), .m_addr(m_addr), .m_as_(m_as_), .m_rw(m_rw),
    .m_wr_data(m_wr_data), .m_grnt_(m_grnt_), .m_rd_data(m_rd_data),
    .m_rdy_(m_rdy_), .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw),
    .s_wr_data(s_wr_data), .s_cs_(s_cs_), .s_rd_data(s_rd_data),
    .s_rdy_(s_rdy_), .bus_err(bus_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2
  // units after that.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic [ADDR_W-1:0] a, input logic as_,
                            input logic rw, input logic [DATA_W-1:0] wd);
    m_addr[m*ADDR_W +: ADDR_W]    = a;
    m_as_[m]                      = as_;
    m_rw[m]                       = rw;
    m_wr_data[m*DATA_W +: DATA_W] = wd;
  endtask

  function automatic int grant_idx(input logic [NUM_M-1:0] g);
    int r;
    r = -1;
    for (int i = 0; i < NUM_M; i++) if (!g[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              as_;
    logic              rw;
    logic [DATA_W-1:0] wd;
    logic [NUM_S-1:0]  rdy_;
    logic [NUM_S-1:0]  cs;
    logic              mrdy_;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  vec_t vecs[6];
  int   exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [NUM_M-1:0] g, prev_g;
    int               got, exp_i, pulses;
    logic             exp_tmo;

    // addr, as_, rw, wd, s_rdy_, expected s_cs_, m_rdy_, m_rd_data
    vecs[0] = '{30'h1000_0004, 1'b0, 1'b1, 32'h0,         8'hFF, 8'b1111_1011, 1'b1, 32'h1234_5678};
    vecs[1] = '{30'h1000_0004, 1'b0, 1'b1, 32'h0,         8'hFB, 8'b1111_1011, 1'b0, 32'h1234_5678};
    vecs[2] = '{30'h2800_0000, 1'b0, 1'b0, 32'hCAFE_F00D, 8'hDF, 8'b1101_1111, 1'b0, 32'h5000_0005};
    vecs[3] = '{30'h3800_0010, 1'b1, 1'b1, 32'h0,         8'h00, 8'b0111_1111, 1'b1, 32'h0};
    vecs[4] = '{30'h0000_0000, 1'b0, 1'b1, 32'h0,         8'hFE, 8'b1111_1110, 1'b0, 32'h5000_0000};
    vecs[5] = '{30'h0FFF_FFFF, 1'b0, 1'b1, 32'h0,         8'hFF, 8'b1111_1101, 1'b1, 32'h5000_0001};

    for (int j = 0; j < NUM_S; j++) s_rd_data[j*DATA_W +: DATA_W] = 32'h5000_0000 | j;
    s_rd_data[2*DATA_W +: DATA_W] = 32'h1234_5678;

    reset     = 1'b1;
    m_req_    = '1;
    m_as_     = '1;
    m_rw      = '1;
    m_addr    = '0;
    m_wr_data = '0;
    s_rdy_    = '1;

    // ---- reset state ----
    step(); step();
    #2;
    check("rst_grant",    m_grnt_,   4'b1111);
    check("rst_s_as",     s_as_,     1'b1);
    check("rst_s_cs",     s_cs_,     8'hFF);
    check("rst_s_addr",   s_addr,    '0);
    check("rst_s_rw",     s_rw,      1'b1);
    check("rst_m_rdy",    m_rdy_,    1'b1);
    check("rst_m_rdata",  m_rd_data, '0);
    check("rst_bus_err",  bus_err,   1'b0);
    check("rst_err_addr", err_addr,  '0);
    @(negedge clk) reset = 1'b0;

    // ---- grant latency and one-cycle handover ----
    step();
    m_req_ = 4'b1010;                  // cycle 0: masters 0 and 2
    #2 check("c0_grant", m_grnt_, 4'b1111);
    step();
    #2 check("c1_grant", m_grnt_, 4'b1110);
    step(); step();
    m_req_ = 4'b1011;                  // cycle 3: master 0 releases
    #2 check("c3_grant", m_grnt_, 4'b1110);
    step();
    #2 check("c4_handover", m_grnt_, 4'b1011);
    set_master(2, 30'h1000_0004, 1'b0, 1'b1, 32'h0);
    #2 check("own2_s_cs", s_cs_, 8'b1111_1011);

    // ---- asynchronous reset mid-transfer ----
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("arst_grant",   m_grnt_, 4'b1111);
    check("arst_s_as",    s_as_,   1'b1);
    check("arst_s_cs",    s_cs_,   8'hFF);
    check("arst_bus_err", bus_err, 1'b0);
    step();
    @(negedge clk);
    reset  = 1'b0;
    m_req_ = '1;
    set_master(2, '0, 1'b1, 1'b1, '0);

    // ---- round-robin order, each owner releasing after one cycle ----
    step();
    m_req_ = '0;
    exp_q  = '{0, 1, 2, 3, 0, 1};
    prev_g = '1;
    for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
      step();
      g = m_grnt_;
      check("rr_grant_legal", (g == '1) || $onehot(~g), 1'b1);
      if (g != '1 && g != prev_g) begin
        got   = grant_idx(g);
        exp_i = exp_q.pop_front();
        check($sformatf("rr_order_%0d", cyc), got, exp_i);
      end
      prev_g = g;
      m_req_ = '0;
      if (g != '1) m_req_[grant_idx(g)] = 1'b1;
    end
    check("rr_all_seen", exp_q.size(), 0);
    m_req_ = '1;
    step(); step();
    #2 check("rr_idle_grant", m_grnt_, 4'b1111);

    // ---- decode / mux vector table with master 1 as owner ----
    m_req_ = 4'b1101;
    step(); step();
    #2 check("tbl_grant", m_grnt_, 4'b1101);
    for (int i = 0; i < 6; i++) begin
      step();
      set_master(1, vecs[i].addr, vecs[i].as_, vecs[i].rw, vecs[i].wd);
      s_rdy_ = vecs[i].rdy_;
      #2;
      check($sformatf("tbl%0d_s_cs", i),    s_cs_,     vecs[i].cs);
      check($sformatf("tbl%0d_m_rdy", i),   m_rdy_,    vecs[i].mrdy_);
      check($sformatf("tbl%0d_m_rdata", i), m_rd_data, vecs[i].rdata);
      check($sformatf("tbl%0d_s_addr", i),  s_addr,    vecs[i].addr);
      check($sformatf("tbl%0d_s_as", i),    s_as_,     vecs[i].as_);
      check($sformatf("tbl%0d_s_rw", i),    s_rw,      vecs[i].rw);
      check($sformatf("tbl%0d_s_wdata", i), s_wr_data, vecs[i].wd);
    end
    set_master(1, '0, 1'b1, 1'b1, '0);
    s_rdy_ = '1;
    m_req_ = '1;
    step(); step();

    // ---- stalled read of slave 5: timeout or indefinite stall ----
    set_master(0, 30'h2800_0000, 1'b1, 1'b1, '0);
    m_req_ = 4'b1110;
    step(); step();
    #2 check("tmo_grant", m_grnt_, 4'b1110);
    step();
    m_as_[0] = 1'b0;                   // cycle 0 of the access
    pulses   = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      #2;
      exp_tmo = TMO_EN && (k == 15);
      check($sformatf("tmo_m_rdy_%0d", k),   m_rdy_,  !exp_tmo);
      check($sformatf("tmo_bus_err_%0d", k), bus_err, exp_tmo);
      check($sformatf("tmo_m_rdata_%0d", k), m_rd_data,
            exp_tmo ? 32'hDEAD_BEEF : 32'h5000_0005);
      if (bus_err) pulses++;
    end
    check("tmo_pulses",   pulses,   TMO_EN ? 1 : 0);
    check("tmo_err_addr", err_addr, TMO_EN ? 30'h2800_0000 : 30'h0);

    // ---- reset during a stalled access, then a normal access ----
    m_as_[0] = 1'b1;
    step();
    m_as_[0] = 1'b0;
    for (int k = 0; k < 8; k++) step();
    #2 reset = 1'b1;
    #1;
    check("stall_rst_grant",   m_grnt_, 4'b1111);
    check("stall_rst_bus_err", bus_err, 1'b0);
    check("stall_rst_s_cs",    s_cs_,   8'hFF);
    set_master(0, 30'h0, 1'b0, 1'b1, '0);
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (k == 9) s_rdy_ = 8'hFE;
      #2;
      check($sformatf("post_bus_err_%0d", k), bus_err, 1'b0);
      check($sformatf("post_m_rdy_%0d", k),   m_rdy_,  (k >= 9) ? 1'b0 : 1'b1);
      if (k == 9) check("post_m_rdata", m_rd_data, 32'h5000_0000);
    end

    m_req_ = '1;
    m_as_  = '1;
    s_rdy_ = '1;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
